// File: rtl/dsi_packet_assembler.sv
// DSI short/long packet builder: header word {ECC,WC,DI}, payload words, then a 16-bit CRC word.
// Header is visible one cycle after start acceptance; the output register holds while out_ready is low.
module ecc_calc (
  input  logic [23:0] data,
  output logic [7:0]  ecc
);
  assign ecc[0] = data[0] ^ data[1] ^ data[2] ^ data[4] ^ data[5] ^ data[7] ^ data[10] ^
                  data[11] ^ data[13] ^ data[16] ^ data[20] ^ data[21] ^ data[22] ^ data[23];
  assign ecc[1] = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6] ^ data[8] ^ data[10] ^
                  data[12] ^ data[14] ^ data[17] ^ data[20] ^ data[21] ^ data[22] ^ data[23];
  assign ecc[2] = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6] ^ data[9] ^ data[11] ^
                  data[12] ^ data[15] ^ data[18] ^ data[20] ^ data[21] ^ data[22];
  assign ecc[3] = data[1] ^ data[2] ^ data[3] ^ data[7] ^ data[8] ^ data[9] ^ data[13] ^
                  data[14] ^ data[15] ^ data[19] ^ data[20] ^ data[21] ^ data[23];
  assign ecc[4] = data[4] ^ data[5] ^ data[6] ^ data[7] ^ data[8] ^ data[9] ^ data[16] ^
                  data[17] ^ data[18] ^ data[19] ^ data[20] ^ data[22] ^ data[23];
  assign ecc[5] = data[10] ^ data[11] ^ data[12] ^ data[13] ^ data[14] ^ data[15] ^ data[16] ^
                  data[17] ^ data[18] ^ data[19] ^ data[21] ^ data[22] ^ data[23];
  assign ecc[7:6] = 2'b00;
endmodule

// CRC-16 x^16+x^12+x^5+1, LSB-first (reflected 0x8408), over bytes 0..bytes_number of data.
module crc_calculator (
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [1:0]  bytes_number,
  output logic [15:0] crc_out
);
  logic fb;
  always_comb begin
    crc_out = crc_in;
    fb      = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b[1:0] <= bytes_number) begin
        for (int k = 0; k < 8; k++) begin
          fb      = crc_out[0] ^ data[8*b+k];
          crc_out = {1'b0, crc_out[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
      end
    end
  end
endmodule

module dsi_packet_assembler #(
  parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        abort,
  input  logic        pkt_start,
  input  logic [7:0]  pkt_di,
  input  logic [15:0] pkt_wc,
  input  logic        pkt_long,
  output logic        pkt_ready,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_bytes,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, HDR, PLD, CRC} state_t;

  state_t      state;
  logic [15:0] remaining;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        is_long;
  logic        out_free;
  logic        pld_acc;
  logic [1:0]  pld_n1;
  logic [7:0]  hdr_ecc;
  logic [31:0] pld_masked;

  assign out_free  = !out_valid || out_ready;
  assign pkt_ready = (state == IDLE);
  // Payload is fetched while the header drains so header and first payload word go out back to back.
  assign pld_ready = !abort && out_free && (remaining != 16'd0) && (state == HDR || state == PLD);
  assign pld_acc   = pld_valid && pld_ready;
  assign pld_n1    = (remaining >= 16'd4) ? 2'd3 : (remaining[1:0] - 2'd1);

  always_comb begin
    pld_masked = pld_data;
    if (pld_n1 < 2'd3) pld_masked[31:24] = 8'h00;
    if (pld_n1 < 2'd2) pld_masked[23:16] = 8'h00;
    if (pld_n1 < 2'd1) pld_masked[15:8]  = 8'h00;
  end

  ecc_calc u_ecc (
    .data ({pkt_wc, pkt_di}),
    .ecc  (hdr_ecc)
  );

  crc_calculator u_crc (
    .crc_in       (crc),
    .data         (pld_data),
    .bytes_number (pld_n1),
    .crc_out      (crc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
      remaining <= '0;
      crc       <= CRC_SEED;
      is_long   <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (pkt_start) begin
          out_data  <= {hdr_ecc, pkt_wc[15:8], pkt_wc[7:0], pkt_di};
          out_bytes <= 2'd3;
          out_last  <= !pkt_long;
          out_valid <= 1'b1;
          remaining <= pkt_long ? pkt_wc : 16'd0;
          is_long   <= pkt_long;
          crc       <= CRC_SEED;
          state     <= HDR;
        end
        HDR, PLD: begin
          if (pld_acc) begin
            out_data  <= pld_masked;
            out_bytes <= pld_n1;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            remaining <= remaining - {14'd0, pld_n1} - 16'd1;
            crc       <= crc_next;
            state     <= PLD;
          end else if (out_free) begin
            if (remaining != 16'd0) begin
              out_valid <= 1'b0;
            end else if (is_long) begin
              out_data  <= {16'h0000, crc};
              out_bytes <= 2'd1;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
              state     <= CRC;
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        CRC: if (out_free) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler: table of header vectors plus hand sequences for payload,
// stalls, abort and mid-packet reset; CRC expectations come from a bit-serial reference LFSR.
module tb_dsi_packet_assembler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        abort = 1'b0;
  logic        pkt_start = 1'b0;
  logic [7:0]  pkt_di = '0;
  logic [15:0] pkt_wc = '0;
  logic        pkt_long = 1'b0;
  logic        pkt_ready;
  logic [31:0] pld_data = '0;
  logic        pld_valid = 1'b0;
  logic        pld_ready;
  logic [31:0] out_data;
  logic [1:0]  out_bytes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;

  dsi_packet_assembler #(.CRC_SEED(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .pkt_start(pkt_start), .pkt_di(pkt_di), .pkt_wc(pkt_wc), .pkt_long(pkt_long),
    .pkt_ready(pkt_ready),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  nb;
    logic        last;
  } word_t;

  typedef struct packed {
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
    logic [31:0] exp_hdr;
  } vec_t;

  word_t       got_q[$];
  word_t       exp_q[$];
  word_t       ref_q[$];
  int          stamp_q[$];
  logic [31:0] pld_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [1:0] nb);
    logic [31:0] r = d;
    for (int i = 0; i < 4; i++) if (i > int'(nb)) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic word_t mk(input logic [31:0] d, input logic [1:0] nb, input logic last);
    word_t w;
    w.dat = d; w.nb = nb; w.last = last;
    return w;
  endfunction

  // Reference CRC: LFSR with taps at 15, 10, 3 after the right shift, fed LSB first.
  function automatic logic [15:0] pld_crc(input int wc);
    logic [15:0] c = 16'hFFFF;
    logic [31:0] w;
    logic [7:0]  b;
    logic        fb;
    for (int i = 0; i < wc; i++) begin
      w = pld_q[i / 4];
      b = w[8*(i % 4) +: 8];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c = c >> 1;
        if (fb) begin c[15] = 1'b1; c[10] = ~c[10]; c[3] = ~c[3]; end
      end
    end
    return c;
  endfunction

  task automatic build_long_exp(input logic [31:0] hdr, input int wc);
    int rem = wc;
    int idx = 0;
    int n;
    exp_q.delete();
    exp_q.push_back(mk(hdr, 2'd3, 1'b0));
    while (rem > 0) begin
      n = (rem >= 4) ? 4 : rem;
      exp_q.push_back(mk(mask_word(pld_q[idx], 2'(n - 1)), 2'(n - 1), 1'b0));
      rem -= n;
      idx++;
    end
    exp_q.push_back(mk({16'h0000, pld_crc(wc)}, 2'd1, 1'b1));
  endtask

  task automatic compare(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_w%0d_dat", name, i), mask_word(got_q[i].dat, got_q[i].nb), exp_q[i].dat);
      chk($sformatf("%s_w%0d_bytes", name, i), 32'(got_q[i].nb), 32'(exp_q[i].nb));
      chk($sformatf("%s_w%0d_last", name, i), 32'(got_q[i].last), 32'(exp_q[i].last));
    end
  endtask

  // Call aligned just after a rising edge; returns just after the accepting edge.
  task automatic start_pkt(input logic [7:0] di, input logic [15:0] wc, input logic lng);
    bit acc = 1'b0;
    int n = 0;
    pkt_di = di; pkt_wc = wc; pkt_long = lng; pkt_start = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = pkt_ready;
      @(posedge clk); #1;
      n++;
    end
    pkt_start = 1'b0;
    if (!acc) chk("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_packet(input logic [7:0] di, input logic [15:0] wc, input logic lng, input bit stall);
    got_q.delete();
    stamp_q.delete();
    out_ready = 1'b1;
    start_pkt(di, wc, lng);
    fork
      begin
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < pld_q.size() && guard < 2000) begin
          pld_data  = pld_q[idx];
          pld_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          @(negedge clk);
          acc = pld_valid && pld_ready;
          @(posedge clk); #1;
          if (acc) idx++;
          guard++;
        end
        pld_valid = 1'b0;
        if (idx < pld_q.size()) chk("payload_timeout", 32'(idx), 32'(pld_q.size()));
      end
      begin
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_dat = '0;
        int guard = 0;
        while (!done && guard < 3000) begin
          @(negedge clk);
          if (prev_stall) begin
            chk("stall_valid_held", 32'(out_valid), 32'd1);
            chk("stall_data_held", out_data, prev_dat);
          end
          prev_stall = out_valid && !out_ready;
          prev_dat   = out_data;
          if (out_valid && out_ready) begin
            got_q.push_back(mk(out_data, out_bytes, out_last));
            stamp_q.push_back(cyc);
            if (out_last) done = 1'b1;
          end
          if (!done) begin
            @(posedge clk); #1;
            if (stall) out_ready = 1'($urandom_range(0, 1));
          end
          guard++;
        end
        out_ready = 1'b1;
        if (!done) chk("last_timeout", 32'd0, 32'd1);
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{8'h01, 16'h0000, 1'b0, 32'h07000001};
    vecs[1] = '{8'h15, 16'h0000, 1'b0, 32'h19000015};
    vecs[2] = '{8'h05, 16'hFF00, 1'b0, 32'h39FF0005};
    vecs[3] = '{8'h29, 16'h0000, 1'b1, 32'h1C000029};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_pld_ready", 32'(pld_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_bytes", 32'(out_bytes), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd1);
    @(posedge clk); #1;

    // Header table: short packets and long WC=0
    foreach (vecs[v]) begin
      pld_q.delete();
      run_packet(vecs[v].di, vecs[v].wc, vecs[v].lng, 1'b0);
      exp_q.delete();
      exp_q.push_back(mk(vecs[v].exp_hdr, 2'd3, !vecs[v].lng));
      if (vecs[v].lng) exp_q.push_back(mk(32'h0000FFFF, 2'd1, 1'b1));
      compare($sformatf("vec%0d", v));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_ready_after", v), 32'(pkt_ready), 32'd1);
      chk($sformatf("vec%0d_idle_valid", v), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Long WC=5: partial last word, upper bytes ignored, no bubbles
    pld_q = '{32'h44332211, 32'hAABBCC55};
    run_packet(8'h29, 16'd5, 1'b1, 1'b0);
    exp_q.delete();
    exp_q.push_back(mk(32'h25000529, 2'd3, 1'b0));
    exp_q.push_back(mk(32'h44332211, 2'd3, 1'b0));
    exp_q.push_back(mk(32'h00000055, 2'd0, 1'b0));
    exp_q.push_back(mk({16'h0000, pld_crc(5)}, 2'd1, 1'b1));
    compare("wc5");
    for (int i = 1; i < stamp_q.size(); i++)
      chk($sformatf("wc5_no_bubble%0d", i), 32'(stamp_q[i] - stamp_q[i-1]), 32'd1);
    @(posedge clk); #1;

    // WC=12 without and with random stalls
    pld_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    build_long_exp(32'h1A000C29, 12);
    run_packet(8'h29, 16'd12, 1'b1, 1'b0);
    compare("wc12_nostall");
    ref_q = got_q;
    @(posedge clk); #1;
    run_packet(8'h29, 16'd12, 1'b1, 1'b1);
    compare("wc12_stall");
    chk("wc12_same_count", got_q.size(), ref_q.size());
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      chk($sformatf("wc12_same_w%0d", i), 32'(got_q[i] == ref_q[i]), 32'd1);
    @(posedge clk); #1;

    // Abort while the second payload word is stalled in the output register
    pld_data = 32'hDEADBEEF; pld_valid = 1'b1; out_ready = 1'b1;
    start_pkt(8'h29, 16'd12, 1'b1);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("abort_pre_valid", 32'(out_valid), 32'd1);
    chk("abort_pre_data", out_data, 32'hDEADBEEF);
    chk("abort_pre_pld_ready", 32'(pld_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; pld_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_pkt_ready", 32'(pkt_ready), 32'd1);
    chk("abort_pld_ready", 32'(pld_ready), 32'd0);
    @(posedge clk); #1;
    pld_q = '{32'h04030201, 32'h00000005};
    build_long_exp(32'h25000529, 5);
    run_packet(8'h29, 16'd5, 1'b1, 1'b0);
    compare("post_abort");
    @(posedge clk); #1;

    // Reset during payload, then a clean packet
    pld_data = 32'h12345678; pld_valid = 1'b1;
    start_pkt(8'h29, 16'd12, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_bytes", 32'(out_bytes), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    chk("mid_rst_pld_ready", 32'(pld_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; pld_valid = 1'b0;
    @(posedge clk); #1;
    pld_q = '{32'hA1B2C3D4, 32'h11223344, 32'hFFEE0099};
    build_long_exp(32'h1A000C29, 12);
    run_packet(8'h29, 16'd12, 1'b1, 1'b0);
    compare("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
